lcd_panel_rx: RTL and testbench

LCD_PANEL_RX -- requirements
Module: lcd_panel_rx

---
 rtl/lcd_panel_rx.sv | 150 +++++++++++++++
 tb/tb_lcd_panel_rx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/lcd_panel_rx.sv
// LCD panel pin receiver: packs 2-bit shades into bytes and tracks line/frame position.
// Define LCD_PANEL_RX_FR_CHECK_EN to enable the frame-polarity alternation check on err_fr.
module lcd_panel_rx (
  input  logic       clk2,
  input  logic       nreset_video,
  input  logic       cp,
  input  logic       st,
  input  logic       s,
  input  logic       fr,
  input  logic [1:0] ld,
  output logic [7:0] px_data,
  output logic       px_valid,
  output logic [5:0] px_x,
  output logic [7:0] ly,
  output logic       line_done,
  output logic       frame_start,
  output logic       err_len,
  output logic       err_fr
);

  localparam logic [7:0] LINE_PIXELS = 8'd160;

  typedef enum logic [1:0] {SYNC, LINE, FULL} state_t;

  state_t     state, state_n;
  logic       cp_q, st_q, s_q;
  logic       cp_edge, st_edge, s_edge;
  logic [7:0] x, x_n;
  logic [5:0] acc, acc_n;
  logic [7:0] ly_n, px_data_n;
  logic [5:0] px_x_n;
  logic       px_valid_n, line_done_n, frame_start_n, err_len_n;

  assign cp_edge = cp & ~cp_q;
  assign st_edge = st & ~st_q;
  assign s_edge  = s  & ~s_q;

  // NOTE: every variable driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_n       = state;
    x_n           = x;
    acc_n         = acc;
    ly_n          = ly;
    px_data_n     = px_data;
    px_x_n        = px_x;
    px_valid_n    = 1'b0;
    line_done_n   = 1'b0;
    frame_start_n = 1'b0;
    err_len_n     = err_len;

    case (state)
      SYNC: begin
        if (s_edge) begin
          state_n = LINE;
          x_n     = '0;
          acc_n   = '0;
          ly_n    = '0;
        end
      end
      LINE, FULL: begin
        // Order matters: the pixel is counted before st, and s overrides the line number st produced.
        if (cp_edge) begin
          if (state == LINE) begin
            acc_n = {acc[3:0], ld};
            x_n   = x + 8'd1;
            if (x[1:0] == 2'd3) begin
              px_valid_n = 1'b1;
              px_data_n  = {acc, ld};
              px_x_n     = x[7:2];
            end
            if (x_n == LINE_PIXELS) state_n = FULL;
          end else begin
            err_len_n = 1'b1;
          end
        end
        if (st_edge) begin
          line_done_n = 1'b1;
          if (x_n != LINE_PIXELS) err_len_n = 1'b1;
          x_n     = '0;
          acc_n   = '0;
          ly_n    = ly + 8'd1;
          state_n = LINE;
        end
        if (s_edge) begin
          frame_start_n = 1'b1;
          x_n     = '0;
          acc_n   = '0;
          ly_n    = '0;
          state_n = LINE;
        end
      end
      default: state_n = SYNC;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the pre-edge values of the others.
  always_ff @(posedge clk2) begin
    if (!nreset_video) begin
      state       <= SYNC;
      cp_q        <= 1'b0;
      st_q        <= 1'b0;
      s_q         <= 1'b0;
      x           <= '0;
      acc         <= '0;
      ly          <= '0;
      px_data     <= '0;
      px_x        <= '0;
      px_valid    <= 1'b0;
      line_done   <= 1'b0;
      frame_start <= 1'b0;
      err_len     <= 1'b0;
    end else begin
      state       <= state_n;
      cp_q        <= cp;
      st_q        <= st;
      s_q         <= s;
      x           <= x_n;
      acc         <= acc_n;
      ly          <= ly_n;
      px_data     <= px_data_n;
      px_x        <= px_x_n;
      px_valid    <= px_valid_n;
      line_done   <= line_done_n;
      frame_start <= frame_start_n;
      err_len     <= err_len_n;
    end
  end

`ifdef LCD_PANEL_RX_FR_CHECK_EN
  logic fr_q, fr_seen;

  // The first s edge after reset only records fr; later edges require it to have toggled.
  always_ff @(posedge clk2) begin
    if (!nreset_video) begin
      fr_q    <= 1'b0;
      fr_seen <= 1'b0;
      err_fr  <= 1'b0;
    end else if (s_edge) begin
      fr_q    <= fr;
      fr_seen <= 1'b1;
      if (fr_seen && (fr == fr_q)) err_fr <= 1'b1;
    end
  end
`else
  logic unused_fr;
  assign unused_fr = fr;
  assign err_fr    = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_panel_rx.sv
// Scoreboard bench for lcd_panel_rx: expected pixel groups are queued as pixels are driven
// and compared when px_valid appears; line/frame/error behaviour is checked directly.
module tb_lcd_panel_rx;

  logic       clk2 = 1'b0;
  logic       nreset_video = 1'b0;
  logic       cp = 1'b0, st = 1'b0, s = 1'b0, fr = 1'b0;
  logic [1:0] ld = 2'd0;
  logic [7:0] px_data;
  logic       px_valid;
  logic [5:0] px_x;
  logic [7:0] ly;
  logic       line_done, frame_start, err_len, err_fr;

  lcd_panel_rx dut (
    .clk2(clk2), .nreset_video(nreset_video), .cp(cp), .st(st), .s(s), .fr(fr), .ld(ld),
    .px_data(px_data), .px_valid(px_valid), .px_x(px_x), .ly(ly),
    .line_done(line_done), .frame_start(frame_start), .err_len(err_len), .err_fr(err_fr)
  );

  always #5 clk2 = ~clk2;

`ifdef LCD_PANEL_RX_FR_CHECK_EN
  localparam logic FR_EN = 1'b1;
`else
  localparam logic FR_EN = 1'b0;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [13:0] exp_q[$];   // {px_data, px_x}
  int          mx;         // model pixel count within the line
  logic [7:0]  grp;        // model shade shift register
  logic        ld_seen, fs_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Monitor: every px_valid must match the oldest queued group.
  always @(negedge clk2) begin
    if (px_valid === 1'b1) begin
      check("px_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        logic [13:0] e;
        e = exp_q.pop_front();
        check("px_data", {24'd0, px_data}, {24'd0, e[13:6]});
        check("px_x", {26'd0, px_x}, {26'd0, e[5:0]});
      end
    end
  end

  // Raise the selected strobes for one cycle; outputs reacting to them are captured a cycle later.
  task automatic strobe(input logic c, input logic t, input logic v, input logic [1:0] d);
    @(negedge clk2);
    cp = c; st = t; s = v; ld = d;
    @(negedge clk2);
    ld_seen = line_done;
    fs_seen = frame_start;
    cp = 1'b0; st = 1'b0; s = 1'b0;
  endtask

  task automatic model_pix(input logic [1:0] d);
    if (mx < 160) begin
      grp = {grp[5:0], d};
      mx++;
      if (mx % 4 == 0) exp_q.push_back({grp, 6'(mx / 4 - 1)});
    end
  endtask

  task automatic model_line_end();
    mx  = 0;
    grp = '0;
  endtask

  task automatic pix(input logic [1:0] d);
    model_pix(d);
    strobe(1'b1, 1'b0, 1'b0, d);
  endtask

  task automatic pixels(input int n);
    for (int i = 0; i < n; i++) pix(2'(i % 4));
  endtask

  task automatic do_reset(input logic s_level);
    @(negedge clk2);
    nreset_video = 1'b0;
    cp = 1'b0; st = 1'b0; s = s_level;
    repeat (2) @(negedge clk2);
    check("rst_outputs",
          {17'd0, px_data, px_valid, px_x, line_done, frame_start, err_len, err_fr},
          32'd0);
    check("rst_ly", {24'd0, ly}, 32'd0);
    check("rst_queue_empty", exp_q.size(), 0);
    exp_q.delete();
    model_line_end();
    nreset_video = 1'b1;
  endtask

  task automatic frame_edge();
    strobe(1'b0, 1'b0, 1'b1, 2'd0);
    model_line_end();
  endtask

  initial begin
    mx = 0; grp = '0;
    repeat (3) @(negedge clk2);

    // Line capture, then a line whose last pixel coincides with st.
    do_reset(1'b0);
    frame_edge();
    pixels(160);
    strobe(1'b0, 1'b1, 1'b0, 2'd0); model_line_end();
    check("cap_line_done", {31'd0, ld_seen}, 32'd1);
    check("cap_ly", {24'd0, ly}, 32'd1);
    check("cap_err_len", {31'd0, err_len}, 32'd0);
    check("cap_queue_empty", exp_q.size(), 0);
    pixels(159);
    model_pix(2'd3);
    strobe(1'b1, 1'b1, 1'b0, 2'd3); model_line_end();
    repeat (2) @(negedge clk2);
    check("cpst_line_done", {31'd0, ld_seen}, 32'd1);
    check("cpst_err_len", {31'd0, err_len}, 32'd0);
    check("cpst_ly", {24'd0, ly}, 32'd2);
    check("cpst_queue_empty", exp_q.size(), 0);

    // s edge mid-frame pulses frame_start; then a short line.
    frame_edge();
    check("s_frame_start", {31'd0, fs_seen}, 32'd1);
    check("s_ly", {24'd0, ly}, 32'd0);
    pixels(100);
    strobe(1'b0, 1'b1, 1'b0, 2'd0); model_line_end();
    repeat (2) @(negedge clk2);
    check("short_line_done", {31'd0, ld_seen}, 32'd1);
    check("short_err_len", {31'd0, err_len}, 32'd1);
    check("short_ly", {24'd0, ly}, 32'd1);
    check("short_queue_empty", exp_q.size(), 0);

    // Overrun.
    do_reset(1'b0);
    frame_edge();
    pixels(160);
    check("ovr_err_len_160", {31'd0, err_len}, 32'd0);
    pix(2'd0);
    check("ovr_err_len_161", {31'd0, err_len}, 32'd1);
    repeat (2) @(negedge clk2);
    check("ovr_queue_empty", exp_q.size(), 0);

    // ly wrap: full first and last line, strobe-only lines in between.
    do_reset(1'b0);
    frame_edge();
    pixels(160);
    strobe(1'b0, 1'b1, 1'b0, 2'd0); model_line_end();
    for (int i = 0; i < 254; i++) strobe(1'b0, 1'b1, 1'b0, 2'd0);
    check("wrap_ly_255", {24'd0, ly}, 32'd255);
    pixels(160);
    strobe(1'b0, 1'b1, 1'b0, 2'd0); model_line_end();
    check("wrap_ly_0", {24'd0, ly}, 32'd0);
    strobe(1'b0, 1'b1, 1'b1, 2'd0); model_line_end();
    check("sts_line_done", {31'd0, ld_seen}, 32'd1);
    check("sts_frame_start", {31'd0, fs_seen}, 32'd1);
    check("sts_ly", {24'd0, ly}, 32'd0);

    // Reset mid-line: partial line discarded, cp ignored until the next s edge.
    do_reset(1'b0);
    frame_edge();
    pixels(50);
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) strobe(1'b1, 1'b0, 1'b0, 2'(i));
    repeat (2) @(negedge clk2);
    check("sync_no_line_done", {31'd0, line_done}, 32'd0);
    check("sync_ly", {24'd0, ly}, 32'd0);

    // s already high across reset: exactly one edge right after reset, so pixels are accepted.
    do_reset(1'b1);
    @(negedge clk2); s = 1'b0;
    pixels(8);
    repeat (2) @(negedge clk2);
    check("hi_s_queue_empty", exp_q.size(), 0);

    // Frame-polarity alternation.
    do_reset(1'b0);
    fr = 1'b1; frame_edge();
    fr = 1'b0; frame_edge();
    check("fr_after_2", {31'd0, err_fr}, 32'd0);
    fr = 1'b0; frame_edge();
    check("fr_after_3", {31'd0, err_fr}, {31'd0, FR_EN});

    repeat (4) @(negedge clk2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
